// File: rtl/lcd_rx_if.sv
// Host-bus and capture-stream bundle for lcd_rx.
// The slave view belongs to the block; the master view belongs to the host/consumer side.
interface lcd_rx_if;
  logic        cs;
  logic        rs;
  logic        wr;
  logic        rd;
  logic [15:0] din;
  logic [15:0] dout;
  logic        doe;
  logic        m_valid;
  logic        m_rs;
  logic [15:0] m_data;
  logic        m_ready;

  modport master (
    output cs, rs, wr, rd, din, m_ready,
    input  dout, doe, m_valid, m_rs, m_data
  );

  modport slave (
    input  cs, rs, wr, rd, din, m_ready,
    output dout, doe, m_valid, m_rs, m_data
  );
endinterface

// File: rtl/lcd_rx.sv
// 8080-style LCD bus receiver: synchronizes an async host bus into pclk,
// captures writes into a show-ahead FIFO and answers reads from rd_data.
module lcd_rx #(
  parameter int DEPTH = 4
) (
  input  logic        pclk,
  input  logic        prst,
  lcd_rx_if.slave     bus,
  input  logic [15:0] rd_data,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, DRIVE} rstate_t;

  rstate_t state, state_n;
  logic    ld_dout;

  logic cs_s1, cs_s2;
  logic rs_s1, rs_s2;
  logic wr_s1, wr_s2, wr_s3;
  logic rd_s1, rd_s2, rd_s3;
  logic [15:0] din_s1, din_s2;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [15:0]   dout_q;
  logic [16:0]   head;

  logic doe_q, wr_ev, pop, full, push, ovf_set, m_valid_q;

  // Strobes/select idle high so release from reset yields no edges
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      wr_s1  <= 1'b1;
      wr_s2  <= 1'b1;
      wr_s3  <= 1'b1;
      rd_s1  <= 1'b1;
      rd_s2  <= 1'b1;
      rd_s3  <= 1'b1;
      rs_s1  <= 1'b0;
      rs_s2  <= 1'b0;
      din_s1 <= '0;
      din_s2 <= '0;
    end else begin
      cs_s1  <= bus.cs;
      cs_s2  <= cs_s1;
      wr_s1  <= bus.wr;
      wr_s2  <= wr_s1;
      wr_s3  <= wr_s2;
      rd_s1  <= bus.rd;
      rd_s2  <= rd_s1;
      rd_s3  <= rd_s2;
      rs_s1  <= bus.rs;
      rs_s2  <= rs_s1;
      din_s1 <= bus.din;
      din_s2 <= din_s1;
    end
  end

  assign doe_q     = (state == DRIVE);
  assign wr_ev     = wr_s2 & ~wr_s3 & ~cs_s2 & rd_s2 & ~doe_q;
  assign m_valid_q = (count != '0);
  assign pop       = m_valid_q & bus.m_ready;
  assign full      = (count == CW'(DEPTH));
  assign push      = wr_ev & (~full | pop);
  assign ovf_set   = wr_ev & full & ~pop;

  always_ff @(posedge pclk) begin
    if (push) mem[wptr] <= {rs_s2, din_s2};
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign head        = mem[rptr];
  assign bus.m_valid = m_valid_q;
  assign bus.m_rs    = m_valid_q & head[16];
  assign bus.m_data  = m_valid_q ? head[15:0] : 16'h0000;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state  <= IDLE;
      dout_q <= '0;
    end else begin
      state <= state_n;
      if (ld_dout) dout_q <= rd_data;
    end
  end

  always_comb begin
    state_n = state;
    ld_dout = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rd_s2 && rd_s3 && !cs_s2) begin
          state_n = DRIVE;
          ld_dout = 1'b1;
        end
      end
      DRIVE: begin
        if (rd_s2 || cs_s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.doe  = doe_q;
  assign bus.dout = dout_q;

endmodule
